// File: rtl/back_pressure_mc_if.sv
// Handshake observation and status bundle for the multi-channel occupancy tracker.
// master drives the observed handshakes and controls; slave is the tracker itself.
interface back_pressure_mc_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CW     = 9
);
    logic [NUM_CH-1:0]    in_valid;
    logic [NUM_CH-1:0]    in_ready;
    logic [NUM_CH-1:0]    out_valid;
    logic [NUM_CH-1:0]    out_ready;
    logic [NUM_CH-1:0]    clear_peak;
    logic                 clear_err;
    logic [NUM_CH-1:0]    almost_full;
    logic                 any_almost_full;
    logic [NUM_CH*CW-1:0] occupancy;
    logic [NUM_CH*CW-1:0] peak;
    logic [NUM_CH-1:0]    err_overflow;
    logic [NUM_CH-1:0]    err_underflow;

    modport master (
        output in_valid, in_ready, out_valid, out_ready, clear_peak, clear_err,
        input  almost_full, any_almost_full, occupancy, peak, err_overflow, err_underflow
    );

    modport slave (
        input  in_valid, in_ready, out_valid, out_ready, clear_peak, clear_err,
        output almost_full, any_almost_full, occupancy, peak, err_overflow, err_underflow
    );
endinterface

// File: rtl/back_pressure_mc.sv
// Per-channel occupancy counters with hysteretic almost-full, peak tracking and
// sticky overflow/underflow flags; observes downstream buffer handshakes only.
module back_pressure_mc #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned MAX_CNT    = 511,
    parameter int unsigned HIGH_LEVEL = 490,
    parameter int unsigned LOW_LEVEL  = 400
) (
    input logic               clk,
    input logic               rst,
    back_pressure_mc_if.slave bp
);
    localparam int unsigned CW = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] MaxCnt  = CW'(MAX_CNT);
    localparam logic [CW-1:0] HighLvl = CW'(HIGH_LEVEL);
    localparam logic [CW-1:0] LowLvl  = CW'(LOW_LEVEL);
    localparam logic [CW-1:0] One     = CW'(1);

    logic [NUM_CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][CW-1:0] peak_q, peak_d;
    logic [NUM_CH-1:0]         af_q, af_d;
    logic                      any_af_q, any_af_d;
    logic [NUM_CH-1:0]         ovf_q, ovf_d;
    logic [NUM_CH-1:0]         unf_q, unf_d;
    logic [NUM_CH-1:0]         inc, dec;

    assign inc = bp.in_valid & bp.in_ready;
    assign dec = bp.out_valid & bp.out_ready;

    always_comb begin
        cnt_d    = cnt_q;
        peak_d   = peak_q;
        af_d     = af_q;
        // Clear first so that an error event below in the same cycle wins.
        ovf_d    = bp.clear_err ? '0 : ovf_q;
        unf_d    = bp.clear_err ? '0 : unf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (inc[i] && !dec[i]) begin
                if (cnt_q[i] == MaxCnt) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + One;
                end
            end else if (dec[i] && !inc[i]) begin
                if (cnt_q[i] == '0) begin
                    unf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - One;
                end
            end

            // Hysteresis works off the registered count, so it trails occupancy by a cycle.
            if (cnt_q[i] >= HighLvl) begin
                af_d[i] = 1'b1;
            end else if (cnt_q[i] < LowLvl) begin
                af_d[i] = 1'b0;
            end

            if (bp.clear_peak[i]) begin
                peak_d[i] = cnt_q[i];
            end else if (cnt_q[i] > peak_q[i]) begin
                peak_d[i] = cnt_q[i];
            end
        end
        any_af_d = |af_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            peak_q   <= '0;
            af_q     <= '0;
            any_af_q <= 1'b0;
            ovf_q    <= '0;
            unf_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            peak_q   <= peak_d;
            af_q     <= af_d;
            any_af_q <= any_af_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bp.occupancy       = cnt_q;
    assign bp.peak            = peak_q;
    assign bp.almost_full     = af_q;
    assign bp.any_almost_full = any_af_q;
    assign bp.err_overflow    = ovf_q;
    assign bp.err_underflow   = unf_q;
endmodule

// File: tb/tb_back_pressure_mc.sv
// Directed bench for back_pressure_mc with two channels, MAX_CNT=7, HIGH=6, LOW=3.
module tb_back_pressure_mc;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned MAX_CNT = 7;
    localparam int unsigned CW = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    back_pressure_mc_if #(.NUM_CH(NUM_CH), .CW(CW)) bp ();

    back_pressure_mc #(
        .NUM_CH    (NUM_CH),
        .MAX_CNT   (MAX_CNT),
        .HIGH_LEVEL(6),
        .LOW_LEVEL (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned occ(input int ch);
        return int'(bp.occupancy[ch*CW +: CW]);
    endfunction

    function automatic int unsigned pk(input int ch);
        return int'(bp.peak[ch*CW +: CW]);
    endfunction

    task automatic idle_inputs();
        bp.in_valid   = '0;
        bp.in_ready   = '0;
        bp.out_valid  = '0;
        bp.out_ready  = '0;
        bp.clear_peak = '0;
        bp.clear_err  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_occ0", occ(0), 0);
        chk("rst_occ1", occ(1), 0);
        chk("rst_af", bp.almost_full, 0);
        chk("rst_any", bp.any_almost_full, 0);

        // 1: fill ch0 to 6; almost_full trails occupancy by one cycle
        bp.in_valid[0] = 1'b1;
        bp.in_ready[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("fill_occ0", occ(0), k);
            chk("fill_af0_low", bp.almost_full[0], 0);
        end
        idle_inputs();
        tick();
        chk("fill_occ0_hold", occ(0), 6);
        chk("fill_af0_set", bp.almost_full[0], 1);
        chk("fill_any_set", bp.any_almost_full, 1);
        chk("fill_occ1", occ(1), 0);
        chk("fill_peak0", pk(0), 6);

        // 2: drain ch0 through the hysteresis band
        bp.out_valid[0] = 1'b1;
        bp.out_ready[0] = 1'b1;
        for (int k = 5; k >= 2; k--) begin
            tick();
            chk("drain_occ0", occ(0), k);
            chk("drain_af0_held", bp.almost_full[0], 1);
            chk("drain_peak0", pk(0), 6);
        end
        idle_inputs();
        tick();
        chk("drain_occ0_2", occ(0), 2);
        chk("drain_af0_clr", bp.almost_full[0], 0);
        chk("drain_any_clr", bp.any_almost_full, 0);
        chk("drain_peak0_end", pk(0), 6);

        // 3: overflow ch1, set-wins-over-clear, then clear
        bp.in_valid[1] = 1'b1;
        bp.in_ready[1] = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        chk("ovf_occ1_full", occ(1), 7);
        chk("ovf_err_none", bp.err_overflow, 0);
        tick();
        chk("ovf_occ1_sat", occ(1), 7);
        chk("ovf_err1_set", bp.err_overflow[1], 1);
        bp.clear_err = 1'b1;
        tick();
        chk("ovf_set_wins", bp.err_overflow[1], 1);
        idle_inputs();
        bp.clear_err = 1'b1;
        tick();
        bp.clear_err = 1'b0;
        chk("ovf_cleared", bp.err_overflow[1], 0);
        chk("ovf_any_ch1", bp.any_almost_full, 1);
        chk("ovf_af_vec", bp.almost_full, 2);

        // 4: underflow ch0, then simultaneous enq+deq at zero
        bp.out_valid[0] = 1'b1;
        bp.out_ready[0] = 1'b1;
        tick();
        tick();
        chk("unf_occ0_zero", occ(0), 0);
        chk("unf_err_none", bp.err_underflow[0], 0);
        tick();
        chk("unf_occ0_hold", occ(0), 0);
        chk("unf_err0_set", bp.err_underflow[0], 1);
        idle_inputs();
        bp.clear_err = 1'b1;
        tick();
        bp.clear_err = 1'b0;
        chk("unf_cleared", bp.err_underflow[0], 0);
        bp.in_valid[0]  = 1'b1;
        bp.in_ready[0]  = 1'b1;
        bp.out_valid[0] = 1'b1;
        bp.out_ready[0] = 1'b1;
        tick();
        chk("both_occ0", occ(0), 0);
        chk("both_unf0", bp.err_underflow[0], 0);
        chk("both_ovf0", bp.err_overflow[0], 0);

        // 5: clear_peak reloads from the registered count
        idle_inputs();
        bp.in_valid[0] = 1'b1;
        bp.in_ready[0] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        idle_inputs();
        chk("pk_occ0", occ(0), 4);
        chk("pk_before", pk(0), 6);
        bp.clear_peak[0] = 1'b1;
        tick();
        chk("pk_clear", pk(0), 4);
        bp.in_valid[0] = 1'b1;
        bp.in_ready[0] = 1'b1;
        tick();
        idle_inputs();
        chk("pk_clear_enq_occ", occ(0), 5);
        chk("pk_clear_enq", pk(0), 4);
        tick();
        chk("pk_follow", pk(0), 5);

        // 6: reset overrides everything with both channels almost full and erroring
        bp.in_valid = 2'b11;
        bp.in_ready = 2'b11;
        tick();
        tick();
        tick();
        idle_inputs();
        tick();
        chk("pre_rst_af", bp.almost_full, 3);
        chk("pre_rst_ovf", bp.err_overflow, 3);
        bp.in_valid = 2'b11;
        bp.in_ready = 2'b11;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        chk("rst2_occ0", occ(0), 0);
        chk("rst2_occ1", occ(1), 0);
        chk("rst2_peak", bp.peak, 0);
        chk("rst2_af", bp.almost_full, 0);
        chk("rst2_any", bp.any_almost_full, 0);
        chk("rst2_ovf", bp.err_overflow, 0);
        chk("rst2_unf", bp.err_underflow, 0);
        tick();
        chk("post_rst_occ", bp.occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
